sg_list_writer_128: RTL and testbench

SG_LIST_WRITER_128 -- requirements
Module: sg_list_writer_128

---
 rtl/sg_pkg.sv | 22 ++
 rtl/sg_dword_packer.sv | 57 +++++
 rtl/sg_list_writer_128.sv | 98 +++++++++
 tb/tb_sg_list_writer_128.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sg_pkg.sv
// Shared SG list writer definitions: element layout, accumulator depth,
// output-stage states and the DATA_EN clamp helper.
package sg_pkg;

    localparam int unsigned SG_ELEM_DWORDS = 4;
    localparam int unsigned SG_ACC_DWORDS  = 7;

    localparam int unsigned SG_ADDR_OFS = 0;
    localparam int unsigned SG_LEN_OFS  = 64;
    localparam int unsigned SG_RSVD_OFS = 96;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // DATA_EN codes above one full beat count as a full beat.
    function automatic logic [2:0] sg_clamp_en(input logic [2:0] en);
        return (en > 3'd4) ? 3'd4 : en;
    endfunction

endpackage

// File: rtl/sg_dword_packer.sv
// Seven-dword accumulator with fill counter: appends accepted dwords at the
// fill position and shifts down one element whenever the top consumes one.
module sg_dword_packer
    import sg_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [127:0] i_data,
    input  logic [2:0]   i_en,
    input  logic         i_xfer,
    input  logic         i_move,
    input  logic         i_flush,
    output logic [2:0]   o_cnt,
    output logic [127:0] o_elem
);

    logic [32*SG_ACC_DWORDS-1:0] r_acc;
    logic [2:0]                  r_cnt;

    logic [32*SG_ACC_DWORDS-1:0] w_acc_nxt;
    logic [2:0]                  w_base;
    logic [2:0]                  w_cnt_nxt;

    // Shift happens first, so appended dwords land at the post-shift count.
    always_comb begin
        w_base    = i_move ? (r_cnt - 3'(SG_ELEM_DWORDS)) : r_cnt;
        w_acc_nxt = i_move ? (r_acc >> (32 * SG_ELEM_DWORDS)) : r_acc;
        if (i_xfer) begin
            for (int unsigned k = 0; k < SG_ELEM_DWORDS; k++) begin
                if ((k < 32'(i_en)) && ((32'(w_base) + k) < SG_ACC_DWORDS)) begin
                    w_acc_nxt[32 * (32'(w_base) + k) +: 32] = i_data[32 * k +: 32];
                end
            end
        end
        if (i_flush) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = w_base + (i_xfer ? i_en : 3'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        r_acc <= w_acc_nxt;
    end

    assign o_cnt  = r_cnt;
    assign o_elem = r_acc[127:0];

endmodule

// File: rtl/sg_list_writer_128.sv
// SG list writer: packs incoming SG dwords into 4-dword elements for the SG
// buffer FIFO. Optional macro SG_WRITER_ZERO_LEN_FILTER_EN drops len==0 elements.
module sg_list_writer_128
    import sg_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128
)
(
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [C_DATA_WIDTH-1:0] DATA,
    input  logic [2:0]              DATA_EN,
    input  logic                    DATA_VALID,
    output logic                    DATA_READY,
    input  logic                    FLUSH,
    output logic [C_DATA_WIDTH-1:0] BUF_DATA,
    output logic                    BUF_DATA_WEN,
    input  logic                    BUF_DATA_FULL,
    output logic [31:0]             ELEM_CNT,
    output logic                    ERR_PARTIAL
);

    out_state_t         r_state;
    out_state_t         w_state_nxt;
    logic [127:0]       r_out_data;
    logic [31:0]        r_elem_cnt;
    logic               r_err;

    logic [2:0]         w_cnt;
    logic [127:0]       w_elem;
    logic [2:0]         w_en;
    logic               w_ready;
    logic               w_xfer;
    logic               w_wen;
    logic               w_move;
    logic               w_load;

    assign w_en    = sg_clamp_en(DATA_EN);
    assign w_ready = (w_cnt < 3'(SG_ELEM_DWORDS));
    assign w_xfer  = DATA_VALID & w_ready & ~FLUSH;
    assign w_wen   = (r_state == OUT_FULL) & ~BUF_DATA_FULL;
    assign w_move  = (w_cnt >= 3'(SG_ELEM_DWORDS)) & ((r_state == OUT_EMPTY) | w_wen);

    // A filtered element is still consumed from the accumulator, just never loaded.
`ifdef SG_WRITER_ZERO_LEN_FILTER_EN
    assign w_load = w_move & (w_elem[SG_LEN_OFS +: 32] != '0);
`else
    assign w_load = w_move;
`endif

    sg_dword_packer u_packer (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_data  (DATA),
        .i_en    (w_en),
        .i_xfer  (w_xfer),
        .i_move  (w_move),
        .i_flush (FLUSH),
        .o_cnt   (w_cnt),
        .o_elem  (w_elem)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: if (w_load) w_state_nxt = OUT_FULL;
            OUT_FULL:  if (w_wen && !w_load) w_state_nxt = OUT_EMPTY;
            default:   w_state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= OUT_EMPTY;
            r_elem_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= FLUSH & (w_cnt != '0);
            if (w_wen) begin
                r_elem_cnt <= r_elem_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_load) begin
            r_out_data <= w_elem;
        end
    end

    assign DATA_READY   = w_ready;
    assign BUF_DATA     = r_out_data;
    assign BUF_DATA_WEN = w_wen;
    assign ELEM_CNT     = r_elem_cnt;
    assign ERR_PARTIAL  = r_err;

endmodule

// File: tb/tb_sg_list_writer_128.sv
// Directed self-checking bench for sg_list_writer_128; FIFO writes are
// captured on the falling edge and compared against hand-built element lists.
module tb_sg_list_writer_128;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [127:0] DATA;
    logic [2:0]   DATA_EN;
    logic         DATA_VALID;
    logic         DATA_READY;
    logic         FLUSH;
    logic [127:0] BUF_DATA;
    logic         BUF_DATA_WEN;
    logic         BUF_DATA_FULL;
    logic [31:0]  ELEM_CNT;
    logic         ERR_PARTIAL;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [31:0]  exp_cnt = '0;
    logic [127:0] wq[$];

    always #5 CLK = ~CLK;

    sg_list_writer_128 #(.C_DATA_WIDTH(128)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .DATA          (DATA),
        .DATA_EN       (DATA_EN),
        .DATA_VALID    (DATA_VALID),
        .DATA_READY    (DATA_READY),
        .FLUSH         (FLUSH),
        .BUF_DATA      (BUF_DATA),
        .BUF_DATA_WEN  (BUF_DATA_WEN),
        .BUF_DATA_FULL (BUF_DATA_FULL),
        .ELEM_CNT      (ELEM_CNT),
        .ERR_PARTIAL   (ERR_PARTIAL)
    );

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && BUF_DATA_WEN === 1'b1) wq.push_back(BUF_DATA);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for DATA_READY, then presents one beat for one edge.
    task automatic send(input logic [2:0] en, input logic [127:0] d);
        int unsigned w = 0;
        while (DATA_READY !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_vec++;
        if (DATA_READY !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready_timeout got %b want 1", DATA_READY);
        end
        DATA = d; DATA_EN = en; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0; DATA_EN = 3'd0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; DATA = '0; DATA_EN = '0; DATA_VALID = 1'b0;
        FLUSH = 1'b0; BUF_DATA_FULL = 1'b0;
        #2;
        n_vec++; if (DATA_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", DATA_READY); end
        n_vec++; if (BUF_DATA_WEN !== 1'b0) begin n_err++; $display("FAIL rst_wen got %b want 0", BUF_DATA_WEN); end
        n_vec++; if (ELEM_CNT !== 32'd0) begin n_err++; $display("FAIL rst_elem_cnt got %h want 0", ELEM_CNT); end
        n_vec++; if (ERR_PARTIAL !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", ERR_PARTIAL); end
        step(); step();
        RST_N = 1'b1;
        step();
        n_vec++; if (DATA_READY !== 1'b1 || BUF_DATA_WEN !== 1'b0) begin
            n_err++; $display("FAIL post_rst ready/wen got %b/%b want 1/0", DATA_READY, BUF_DATA_WEN);
        end
    endtask

    task automatic test_single();
        logic [127:0] e = 128'h00000000_00000040_00000000_00001000;
        wq.delete();
        send(3'd1, 128'h00001000);
        send(3'd1, 128'h00000000);
        send(3'd1, 128'h00000040);
        send(3'd1, 128'h00000000);
        n_vec++; if (DATA_READY !== 1'b0) begin n_err++; $display("FAIL single_ready_cnt4 got %b want 0", DATA_READY); end
        n_vec++; if (BUF_DATA_WEN !== 1'b0) begin n_err++; $display("FAIL single_wen_n1 got %b want 0", BUF_DATA_WEN); end
        step();
        n_vec++; if (BUF_DATA_WEN !== 1'b1) begin n_err++; $display("FAIL single_wen_n2 got %b want 1", BUF_DATA_WEN); end
        n_vec++; if (BUF_DATA !== e) begin n_err++; $display("FAIL single_data got %h want %h", BUF_DATA, e); end
        step();
        exp_cnt = exp_cnt + 1;
        n_vec++; if (BUF_DATA_WEN !== 1'b0) begin n_err++; $display("FAIL single_wen_after got %b want 0", BUF_DATA_WEN); end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL single_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
        n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL single_nwrites got %0d want 1", wq.size()); end
    endtask

    task automatic test_en_edge();
        logic [127:0] e [2];
        e[0] = 128'h000000B4_000000B3_000000B2_000000B1;
        e[1] = 128'h000000C4_000000C3_000000C2_000000C1;
        wq.delete();
        send(3'd0, 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD);
        send(3'd7, e[0]);
        send(3'd5, e[1]);
        repeat (4) step();
        exp_cnt = exp_cnt + 2;
        n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL en_edge_nwrites got %0d want 2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                n_err++; $display("FAIL en_edge_elem%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 'x, e[i]);
            end
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL en_edge_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    task automatic test_pack();
        logic [127:0] e [2];
        e[0] = 128'h000000A4_000000A3_000000A2_000000A1;
        e[1] = 128'h000000A8_000000A7_000000A6_000000A5;
        wq.delete();
        send(3'd3, 128'h0000FFFF_000000A3_000000A2_000000A1);
        n_vec++; if (DATA_READY !== 1'b1) begin n_err++; $display("FAIL pack_ready_cnt3 got %b want 1", DATA_READY); end
        send(3'd3, 128'h0000FFFF_000000A6_000000A5_000000A4);
        n_vec++; if (DATA_READY !== 1'b0) begin n_err++; $display("FAIL pack_ready_cnt6 got %b want 0", DATA_READY); end
        send(3'd2, 128'h0000FFFF_0000FFFF_000000A8_000000A7);
        n_vec++; if (DATA_READY !== 1'b0) begin n_err++; $display("FAIL pack_ready_cnt4 got %b want 0", DATA_READY); end
        repeat (3) step();
        exp_cnt = exp_cnt + 2;
        n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL pack_nwrites got %0d want 2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                n_err++; $display("FAIL pack_elem%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 'x, e[i]);
            end
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL pack_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [127:0] e [3];
        e[0] = 128'h000000E4_000000E3_000000E2_000000E1;
        e[1] = 128'h000000E8_000000E7_000000E6_000000E5;
        e[2] = 128'h000000EC_000000EB_000000EA_000000E9;
        wq.delete();
        BUF_DATA_FULL = 1'b1;
        send(3'd4, e[0]);
        send(3'd4, e[1]);
        DATA = e[2]; DATA_EN = 3'd4; DATA_VALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (BUF_DATA_WEN !== 1'b0 || BUF_DATA !== e[0] || DATA_READY !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d wen/ready/data got %b/%b/%h want 0/0/%h",
                                  i, BUF_DATA_WEN, DATA_READY, BUF_DATA, e[0]);
            end
            step();
        end
        BUF_DATA_FULL = 1'b0;
        #1;
        n_vec++; if (BUF_DATA_WEN !== 1'b1) begin n_err++; $display("FAIL bp_release_wen got %b want 1", BUF_DATA_WEN); end
        step();
        step();
        DATA_VALID = 1'b0; DATA_EN = 3'd0;
        repeat (3) step();
        exp_cnt = exp_cnt + 3;
        n_vec++; if (wq.size() != 3) begin n_err++; $display("FAIL bp_nwrites got %0d want 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                n_err++; $display("FAIL bp_elem%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 'x, e[i]);
            end
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL bp_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    task automatic test_flush();
        logic [127:0] e [2];
        e[0] = 128'h000000F4_000000F3_000000F2_000000F1;
        e[1] = 128'h00000074_00000073_00000072_00000071;
        wq.delete();
        send(3'd3, 128'h00000000_000000F3_000000F2_000000F1);
        send(3'd3, 128'h00000000_000000F6_000000F5_000000F4);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        n_vec++; if (ERR_PARTIAL !== 1'b1) begin n_err++; $display("FAIL flush_err_pulse got %b want 1", ERR_PARTIAL); end
        n_vec++; if (DATA_READY !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", DATA_READY); end
        step();
        n_vec++; if (ERR_PARTIAL !== 1'b0) begin n_err++; $display("FAIL flush_err_once got %b want 0", ERR_PARTIAL); end
        // Flush with CNT==0 and a same-cycle transfer: transfer dropped, no error.
        DATA = 128'h00000000_00000000_000000BB_000000AA; DATA_EN = 3'd2; DATA_VALID = 1'b1; FLUSH = 1'b1;
        step();
        DATA_VALID = 1'b0; DATA_EN = 3'd0; FLUSH = 1'b0;
        n_vec++; if (ERR_PARTIAL !== 1'b0) begin n_err++; $display("FAIL flush_empty_err got %b want 0", ERR_PARTIAL); end
        send(3'd4, e[1]);
        repeat (3) step();
        exp_cnt = exp_cnt + 2;
        n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL flush_nwrites got %0d want 2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                n_err++; $display("FAIL flush_elem%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 'x, e[i]);
            end
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL flush_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    task automatic test_zero_len();
        logic [127:0] z = 128'h00000000_00000000_00000000_00002000;
        logic [127:0] n = 128'h00000000_00000010_00000000_00003000;
        logic [127:0] e [2];
        int unsigned  ne;
`ifdef SG_WRITER_ZERO_LEN_FILTER_EN
        e[0] = n; e[1] = n; ne = 1;
`else
        e[0] = z; e[1] = n; ne = 2;
`endif
        wq.delete();
        send(3'd4, z);
        send(3'd4, n);
        repeat (4) step();
        exp_cnt = exp_cnt + ne;
        n_vec++; if (wq.size() != ne) begin n_err++; $display("FAIL zlen_nwrites got %0d want %0d", wq.size(), ne); end
        for (int i = 0; i < int'(ne); i++) begin
            n_vec++;
            if (i >= wq.size() || wq[i] !== e[i]) begin
                n_err++; $display("FAIL zlen_elem%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 'x, e[i]);
            end
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL zlen_elem_cnt got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] e = 128'h00000044_00000033_00000022_00000011;
        wq.delete();
        send(3'd2, 128'h00000000_00000000_00000099_00000088);
        RST_N = 1'b0;
        #1;
        n_vec++; if (DATA_READY !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", DATA_READY); end
        n_vec++; if (ELEM_CNT !== 32'd0) begin n_err++; $display("FAIL rstmid_elem_cnt got %h want 0", ELEM_CNT); end
        step();
        RST_N = 1'b1;
        exp_cnt = '0;
        repeat (3) step();
        n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL rstmid_nwrites got %0d want 0", wq.size()); end
        n_vec++; if (DATA_READY !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after got %b want 1", DATA_READY); end
        send(3'd4, e);
        repeat (3) step();
        exp_cnt = exp_cnt + 1;
        n_vec++; if (wq.size() != 1 || wq[0] !== e) begin
            n_err++; $display("FAIL rstmid_realign got %0d writes first %h want 1 write %h",
                              wq.size(), (wq.size() > 0) ? wq[0] : 'x, e);
        end
        n_vec++; if (ELEM_CNT !== exp_cnt) begin n_err++; $display("FAIL rstmid_elem_cnt_after got %h want %h", ELEM_CNT, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_en_edge();
        test_pack();
        test_backpressure();
        test_flush();
        test_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
